// File: rtl/video_out_pkg.sv
// Shared 720p60 timing defaults, underflow fill colour and controller state type
// for the AXI-Stream video output path.
package video_out_pkg;

   localparam int DATA_WIDTH_DEF = 24;

   localparam int H_ACTIVE_720P = 1280;
   localparam int H_FP_720P     = 110;
   localparam int H_SYNC_720P   = 40;
   localparam int H_BP_720P     = 220;

   localparam int V_ACTIVE_720P = 720;
   localparam int V_FP_720P     = 5;
   localparam int V_SYNC_720P   = 5;
   localparam int V_BP_720P     = 20;

   localparam int PREFILL_LEVEL_DEF = 512;

   // Magenta makes missing pixels obvious on a monitor.
   localparam logic [23:0] UNDERFLOW_PIXEL_DEF = 24'hFF00FF;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

endpackage

// File: rtl/video_timing_gen.sv
// Horizontal/vertical raster counters with sync and active-region decode.
// Counters are held at the frame origin while i_run is low.
module video_timing_gen #(
   parameter int H_ACTIVE = 1280,
   parameter int H_FP     = 110,
   parameter int H_SYNC   = 40,
   parameter int H_BP     = 220,
   parameter int V_ACTIVE = 720,
   parameter int V_FP     = 5,
   parameter int V_SYNC   = 5,
   parameter int V_BP     = 20
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_run,
   output logic o_active,
   output logic o_hsync_act,
   output logic o_vsync_act,
   output logic o_frame_first,
   output logic o_frame_last
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);

   localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
   localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

   localparam int HS_START = H_ACTIVE + H_FP;
   localparam int HS_END   = H_ACTIVE + H_FP + H_SYNC;
   localparam int VS_START = V_ACTIVE + V_FP;
   localparam int VS_END   = V_ACTIVE + V_FP + V_SYNC;

   logic [HW-1:0] r_h_cnt;
   logic [VW-1:0] r_v_cnt;
   logic          w_h_last;
   logic          w_v_last;

   assign w_h_last = (r_h_cnt == H_LAST);
   assign w_v_last = (r_v_cnt == V_LAST);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_h_cnt <= '0;
         r_v_cnt <= '0;
      end else if (!i_run) begin
         r_h_cnt <= '0;
         r_v_cnt <= '0;
      end else if (w_h_last) begin
         r_h_cnt <= '0;
         r_v_cnt <= w_v_last ? '0 : r_v_cnt + 1'b1;
      end else begin
         r_h_cnt <= r_h_cnt + 1'b1;
      end
   end

   // Decode in integer space so sync end points equal to the total cannot alias.
   assign o_active      = (int'(r_h_cnt) < H_ACTIVE) && (int'(r_v_cnt) < V_ACTIVE);
   assign o_hsync_act   = (int'(r_h_cnt) >= HS_START) && (int'(r_h_cnt) < HS_END);
   assign o_vsync_act   = (int'(r_v_cnt) >= VS_START) && (int'(r_v_cnt) < VS_END);
   assign o_frame_first = (r_h_cnt == '0) && (r_v_cnt == '0);
   assign o_frame_last  = w_h_last && w_v_last;

endmodule

// File: rtl/axis_video_out.sv
// AXI-Stream pixel sink that paces a FIFO out onto a parallel video bus with
// raster timing, prefill gating, whole-frame shutdown and underflow accounting.
module axis_video_out
   import video_out_pkg::*;
#(
   parameter int                    DATA_WIDTH      = DATA_WIDTH_DEF,
   parameter int                    H_ACTIVE        = H_ACTIVE_720P,
   parameter int                    H_FP            = H_FP_720P,
   parameter int                    H_SYNC          = H_SYNC_720P,
   parameter int                    H_BP            = H_BP_720P,
   parameter int                    V_ACTIVE        = V_ACTIVE_720P,
   parameter int                    V_FP            = V_FP_720P,
   parameter int                    V_SYNC          = V_SYNC_720P,
   parameter int                    V_BP            = V_BP_720P,
   parameter bit                    HS_POL          = 1'b1,
   parameter bit                    VS_POL          = 1'b1,
   parameter int                    PREFILL_LEVEL   = PREFILL_LEVEL_DEF,
   parameter logic [DATA_WIDTH-1:0] UNDERFLOW_PIXEL = DATA_WIDTH'(UNDERFLOW_PIXEL_DEF)
) (
   input  logic                  s_axis_aclk,
   input  logic                  s_axis_aresetn,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic [13:0]           axis_rd_data_count,
   input  logic                  enable,
   input  logic                  clear_status,
   output logic [DATA_WIDTH-1:0] vid_data,
   output logic                  vid_de,
   output logic                  vid_hsync,
   output logic                  vid_vsync,
   output logic                  vid_sof,
   output logic                  underflow,
   output logic [15:0]           underflow_count
);

   state_t                r_state;
   logic [DATA_WIDTH-1:0] r_vid_data;
   logic                  r_vid_de;
   logic                  r_vid_hsync;
   logic                  r_vid_vsync;
   logic                  r_vid_sof;
   logic                  r_underflow;
   logic [15:0]           r_underflow_count;

   logic w_run;
   logic w_active;
   logic w_hsync_act;
   logic w_vsync_act;
   logic w_frame_first;
   logic w_frame_last;
   logic w_prefill_ok;
   logic w_fetch;

   assign w_run        = (r_state != IDLE);
   assign w_prefill_ok = (int'(axis_rd_data_count) >= PREFILL_LEVEL);
   // Fetch is purely positional; tvalid never throttles the raster.
   assign w_fetch      = w_run && w_active;

   video_timing_gen #(
      .H_ACTIVE (H_ACTIVE),
      .H_FP     (H_FP),
      .H_SYNC   (H_SYNC),
      .H_BP     (H_BP),
      .V_ACTIVE (V_ACTIVE),
      .V_FP     (V_FP),
      .V_SYNC   (V_SYNC),
      .V_BP     (V_BP)
   ) u_timing (
      .clk           (s_axis_aclk),
      .rst_n         (s_axis_aresetn),
      .i_run         (w_run),
      .o_active      (w_active),
      .o_hsync_act   (w_hsync_act),
      .o_vsync_act   (w_vsync_act),
      .o_frame_first (w_frame_first),
      .o_frame_last  (w_frame_last)
   );

   always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
      if (!s_axis_aresetn) begin
         r_state <= IDLE;
      end else begin
         case (r_state)
            IDLE:    if (enable && w_prefill_ok) r_state <= RUN;
            RUN:     if (!enable) r_state <= DRAIN;
            DRAIN: begin
               // A stopping request only takes effect on the last pixel of a frame.
               if (enable)            r_state <= RUN;
               else if (w_frame_last) r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
      if (!s_axis_aresetn) begin
         r_vid_data  <= '0;
         r_vid_de    <= 1'b0;
         r_vid_hsync <= ~HS_POL;
         r_vid_vsync <= ~VS_POL;
         r_vid_sof   <= 1'b0;
      end else begin
         r_vid_de    <= w_fetch;
         r_vid_hsync <= (w_run && w_hsync_act) ? HS_POL : ~HS_POL;
         r_vid_vsync <= (w_run && w_vsync_act) ? VS_POL : ~VS_POL;
         r_vid_sof   <= w_run && w_frame_first;
         if (!w_fetch)           r_vid_data <= '0;
         else if (s_axis_tvalid) r_vid_data <= s_axis_tdata;
         else                    r_vid_data <= UNDERFLOW_PIXEL;
      end
   end

   always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
      if (!s_axis_aresetn) begin
         r_underflow       <= 1'b0;
         r_underflow_count <= '0;
      end else if (clear_status) begin
         r_underflow       <= 1'b0;
         r_underflow_count <= '0;
      end else if (w_fetch && !s_axis_tvalid) begin
         r_underflow <= 1'b1;
         if (r_underflow_count != 16'hFFFF) r_underflow_count <= r_underflow_count + 1'b1;
      end
   end

   assign s_axis_tready   = w_fetch;
   assign vid_data        = r_vid_data;
   assign vid_de          = r_vid_de;
   assign vid_hsync       = r_vid_hsync;
   assign vid_vsync       = r_vid_vsync;
   assign vid_sof         = r_vid_sof;
   assign underflow       = r_underflow;
   assign underflow_count = r_underflow_count;

endmodule

// File: tb/tb_axis_video_out.sv
// Bench for axis_video_out on a 14x7 raster: a frame-position model checked
// every cycle plus directed literal expectations for each scenario.
module tb_axis_video_out;

   localparam int LINE  = 14;
   localparam int FRAME = 98;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        s_axis_tvalid;
   logic        s_axis_tready;
   logic [23:0] s_axis_tdata;
   logic [13:0] axis_rd_data_count;
   logic        enable;
   logic        clear_status;
   logic [23:0] vid_data;
   logic        vid_de;
   logic        vid_hsync;
   logic        vid_vsync;
   logic        vid_sof;
   logic        underflow;
   logic [15:0] underflow_count;

   int n_checks = 0;
   int n_pass   = 0;
   int k        = 0;
   int pops     = 0;
   bit pop_q    = 1'b0;
   bit chk_en   = 1'b0;

   always #5 clk = ~clk;

   axis_video_out #(
      .DATA_WIDTH      (24),
      .H_ACTIVE        (8),
      .H_FP            (2),
      .H_SYNC          (2),
      .H_BP            (2),
      .V_ACTIVE        (4),
      .V_FP            (1),
      .V_SYNC          (1),
      .V_BP            (1),
      .HS_POL          (1'b1),
      .VS_POL          (1'b1),
      .PREFILL_LEVEL   (4),
      .UNDERFLOW_PIXEL (24'hFF00FF)
   ) dut (
      .s_axis_aclk        (clk),
      .s_axis_aresetn     (rst_n),
      .s_axis_tvalid      (s_axis_tvalid),
      .s_axis_tready      (s_axis_tready),
      .s_axis_tdata       (s_axis_tdata),
      .axis_rd_data_count (axis_rd_data_count),
      .enable             (enable),
      .clear_status       (clear_status),
      .vid_data           (vid_data),
      .vid_de             (vid_de),
      .vid_hsync          (vid_hsync),
      .vid_vsync          (vid_vsync),
      .vid_sof            (vid_sof),
      .underflow          (underflow),
      .underflow_count    (underflow_count)
   );

   // Pixel source: word N of the stream carries value N.
   assign s_axis_tdata = 24'(pops);
   always @(negedge clk) pop_q = s_axis_tready && s_axis_tvalid;
   always @(posedge clk) begin
      #1;
      if (pop_q) pops = pops + 1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks = n_checks + 1;
      if (act === exp) n_pass = n_pass + 1;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Model: a running flag plus a linear position inside the 98-cycle frame.
   bit          m_run;
   bit          m_en_prev;
   int          m_pos;
   logic [23:0] e_data;
   bit          e_de, e_hs, e_vs, e_sof, e_uf;
   int          e_cnt;

   always @(posedge clk or negedge rst_n) begin
      int h, l;
      bit act;
      if (!rst_n) begin
         m_run = 0; m_en_prev = 0; m_pos = 0;
         e_data = '0; e_de = 0; e_hs = 0; e_vs = 0; e_sof = 0; e_uf = 0; e_cnt = 0;
      end else begin
         h   = m_pos % LINE;
         l   = m_pos / LINE;
         act = m_run && (h < 8) && (l < 4);
         e_de   = act;
         e_data = act ? (s_axis_tvalid ? s_axis_tdata : 24'hFF00FF) : 24'h0;
         e_hs   = m_run && (h >= 10) && (h < 12);
         e_vs   = m_run && (l == 5);
         e_sof  = m_run && (m_pos == 0);
         if (clear_status) begin
            e_uf = 0; e_cnt = 0;
         end else if (act && !s_axis_tvalid) begin
            e_uf = 1;
            if (e_cnt < 65535) e_cnt = e_cnt + 1;
         end
         // Running stops after a frame's last cycle once enable has been low for two samples.
         if (m_run) begin
            if (m_pos == FRAME - 1 && !enable && !m_en_prev) begin
               m_run = 0; m_pos = 0;
            end else begin
               m_pos = (m_pos + 1) % FRAME;
            end
         end else if (enable && axis_rd_data_count >= 14'd4) begin
            m_run = 1; m_pos = 0;
         end
         m_en_prev = enable;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("tready", 32'(s_axis_tready),
               32'(m_run && (m_pos % LINE) < 8 && (m_pos / LINE) < 4));
         check("vid_data", 32'(vid_data), 32'(e_data));
         check("vid_de", 32'(vid_de), 32'(e_de));
         check("vid_hsync", 32'(vid_hsync), 32'(e_hs));
         check("vid_vsync", 32'(vid_vsync), 32'(e_vs));
         check("vid_sof", 32'(vid_sof), 32'(e_sof));
         check("underflow", 32'(underflow), 32'(e_uf));
         check("underflow_count", 32'(underflow_count), 32'(e_cnt));
      end
   end

   // Advance to a point 2 ns after the edge that precedes raster position t.
   task automatic goto(input int t);
      while (k < t) begin
         @(posedge clk);
         #2;
         k = k + 1;
      end
   endtask

   initial begin
      rst_n = 1'b0; enable = 1'b0; s_axis_tvalid = 1'b0;
      axis_rd_data_count = 14'd0; clear_status = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      rst_n  = 1'b1;
      chk_en = 1'b1;
      check("rst_de", 32'(vid_de), 32'd0);
      check("rst_tready", 32'(s_axis_tready), 32'd0);

      // Prefill gate
      enable = 1'b1; axis_rd_data_count = 14'd3; s_axis_tvalid = 1'b1;
      repeat (50) @(posedge clk);
      #2;
      check("gate_tready", 32'(s_axis_tready), 32'd0);
      check("gate_pops", 32'(pops), 32'd0);
      axis_rd_data_count = 14'd4;
      @(posedge clk);
      #2;
      k = 0;
      check("start_tready", 32'(s_axis_tready), 32'd1);

      // Steady frame 0
      goto(1);
      check("f0_px0", 32'(vid_data), 32'd0);
      check("f0_sof", 32'(vid_sof), 32'd1);
      goto(6);
      check("f0_px5", 32'(vid_data), 32'd5);
      check("f0_sof_low", 32'(vid_sof), 32'd0);
      goto(11);
      check("f0_hsync", 32'(vid_hsync), 32'd1);
      check("f0_blank_de", 32'(vid_de), 32'd0);
      goto(71);
      check("f0_vsync", 32'(vid_vsync), 32'd1);
      goto(FRAME);
      check("f0_consumed", 32'(pops), 32'd32);

      // Underflow on line 1 of frame 1, positions 17..19
      goto(FRAME + 17);
      s_axis_tvalid = 1'b0;
      goto(FRAME + 18);
      check("uf_pixel", 32'(vid_data), 32'hFF00FF);
      check("uf_flag", 32'(underflow), 32'd1);
      goto(FRAME + 20);
      s_axis_tvalid = 1'b1;
      goto(FRAME + 21);
      check("uf_resume", 32'(vid_data), 32'd43);
      check("uf_count", 32'(underflow_count), 32'd3);
      goto(FRAME + 25);
      check("uf_hsync", 32'(vid_hsync), 32'd1);

      // Clear colliding with an underflow in frame 2
      goto(2 * FRAME + 2);
      s_axis_tvalid = 1'b0; clear_status = 1'b1;
      goto(2 * FRAME + 3);
      s_axis_tvalid = 1'b1; clear_status = 1'b0;
      check("clr_flag", 32'(underflow), 32'd0);
      check("clr_count", 32'(underflow_count), 32'd0);
      check("clr_pixel", 32'(vid_data), 32'hFF00FF);

      // Enable drop on line 2 of frame 3
      goto(3 * FRAME);
      check("f3_start_pops", 32'(pops), 32'd92);
      goto(3 * FRAME + 28);
      enable = 1'b0;
      goto(4 * FRAME);
      check("drain_idle_tready", 32'(s_axis_tready), 32'd0);
      check("drain_consumed", 32'(pops), 32'd124);
      goto(4 * FRAME + 8);
      check("idle_de", 32'(vid_de), 32'd0);
      check("idle_hsync", 32'(vid_hsync), 32'd0);
      check("idle_vsync", 32'(vid_vsync), 32'd0);
      check("idle_pops", 32'(pops), 32'd124);

      // Restart, underflow once, then asynchronous reset mid-line
      enable = 1'b1;
      goto(4 * FRAME + 9);
      check("restart_tready", 32'(s_axis_tready), 32'd1);
      goto(4 * FRAME + 11);
      s_axis_tvalid = 1'b0;
      goto(4 * FRAME + 12);
      s_axis_tvalid = 1'b1;
      check("restart_uf", 32'(underflow), 32'd1);
      goto(4 * FRAME + 14);
      check("pre_rst_de", 32'(vid_de), 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      check("arst_de", 32'(vid_de), 32'd0);
      check("arst_data", 32'(vid_data), 32'd0);
      check("arst_tready", 32'(s_axis_tready), 32'd0);
      check("arst_uf", 32'(underflow), 32'd0);
      check("arst_count", 32'(underflow_count), 32'd0);
      check("arst_hsync", 32'(vid_hsync), 32'd0);
      axis_rd_data_count = 14'd3;
      goto(4 * FRAME + 16);
      rst_n = 1'b1;
      goto(4 * FRAME + 30);
      check("regate_tready", 32'(s_axis_tready), 32'd0);
      check("regate_de", 32'(vid_de), 32'd0);
      axis_rd_data_count = 14'd4;
      goto(4 * FRAME + 31);
      check("regate_start", 32'(s_axis_tready), 32'd1);
      goto(4 * FRAME + 40);

      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/axis_video_out.md
Name: axis_video_out

Overview:
- Downstream consumer of the 24-bit AXI-Stream pixel FIFO, in the 74.25 MHz read-clock domain.
- Generates 720p60 raster timing: hsync, vsync, de.
- Pulls one pixel from the FIFO master port per active-video cycle and drives a registered parallel video bus.
- Waits for a FIFO prefill level before starting; detects and counts underflow.

Parameters:
DATA_WIDTH, 24, pixel width (RGB888)
H_ACTIVE, 1280, active pixels per line
H_FP, 110, horizontal front porch cycles
H_SYNC, 40, hsync width cycles
H_BP, 220, horizontal back porch cycles
V_ACTIVE, 720, active lines per frame
V_FP, 5, vertical front porch lines
V_SYNC, 5, vsync width lines
V_BP, 20, vertical back porch lines
HS_POL, 1, hsync active level
VS_POL, 1, vsync active level
PREFILL_LEVEL, 512, FIFO words required before leaving IDLE
UNDERFLOW_PIXEL, 24'hFF00FF, pixel driven when data is missing

Ports:
s_axis_aclk  in  1  pixel clock, 74.25 MHz
s_axis_aresetn  in  1  asynchronous active-low reset
s_axis_tvalid  in  1  FIFO data valid
s_axis_tready  out  1  pixel fetch strobe to FIFO
s_axis_tdata  in  DATA_WIDTH  FIFO pixel data
axis_rd_data_count  in  14  FIFO read-side occupancy
enable  in  1  run request
clear_status  in  1  single-cycle pulse; clears underflow and underflow_count
vid_data  out  DATA_WIDTH  registered pixel
vid_de  out  1  data enable
vid_hsync  out  1  horizontal sync
vid_vsync  out  1  vertical sync
vid_sof  out  1  one-cycle pulse with the first active pixel of each frame
underflow  out  1  sticky underflow flag
underflow_count  out  16  saturating count of missing pixels

Behaviour:
Clock and reset:
- One clock, s_axis_aclk.
- Reset s_axis_aresetn is asynchronous, active-low; deassertion is synchronised externally.
- Reset values: h_cnt=0, v_cnt=0, state=IDLE, s_axis_tready=0, vid_data=0, vid_de=0, vid_sof=0, underflow=0, underflow_count=0.
- Reset values of syncs: vid_hsync=~HS_POL, vid_vsync=~VS_POL.

Counters:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Counter widths are clog2 of the totals.
- h_cnt wraps H_TOTAL-1 -> 0; v_cnt increments on each h wrap and wraps V_TOTAL-1 -> 0.
- Line order: active, front porch, sync, back porch. Frame order is the same, in lines.
- Sync active when h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); vsync uses v_cnt likewise.

State machine:
- IDLE: counters held at 0, tready=0, outputs blanked (de=0, syncs inactive).
- IDLE -> RUN when enable=1 and axis_rd_data_count >= PREFILL_LEVEL.
- RUN: counters free-run.
- RUN -> DRAIN when enable falls.
- DRAIN: same as RUN but DRAIN -> IDLE at h_cnt=H_TOTAL-1 and v_cnt=V_TOTAL-1. Frames are never truncated.
- If enable rises again during DRAIN, return to RUN.

Handshake and data path:
- s_axis_tready is combinational: (state!=IDLE) and h_cnt<H_ACTIVE and v_cnt<V_ACTIVE.
- tready never depends on tvalid.
- Latency is 1 cycle: vid_de, vid_hsync, vid_vsync and vid_data are registered from the same counter position.
- vid_sof is registered with them; it is 1 when h_cnt=0 and v_cnt=0 in a non-IDLE state.
- On tready and tvalid: vid_data <= tdata.
- On tready and not tvalid: vid_data <= UNDERFLOW_PIXEL, underflow <= 1, underflow_count increments (saturating at 16'hFFFF).
- The raster never stalls.
- Outside active video: vid_data <= 0.

Status:
- clear_status takes priority over a simultaneous underflow event in the same cycle; both are cleared.

Reset mid-frame:
- Immediate return to reset values.
- Leftover FIFO contents are not flushed by this block.

Decomposition:
- Package video_out_pkg holds:
  - 720p timing constants (defaults above).
  - State enum: IDLE, RUN, DRAIN.
  - UNDERFLOW_PIXEL default.
- Sub-module video_timing_gen holds h/v counters, the sync/active decode and a run input.
- The top level owns the FSM, the AXIS handshake, the data register and the status logic.

Test Plan:
Small timing for all scenarios: H 8/2/2/2 (total 14), V 4/1/1/1 (total 7), PREFILL_LEVEL=4.
1. Prefill gate: enable=1, count=3 -> tready stays 0 and de=0 for 50 cycles. count=4 -> next cycle state RUN, tready=1 at h_cnt=0.
2. Steady frame: tvalid held 1, tdata=0,1,2,... -> per line, 8 cycles de=1 with data 0..7. hsync high at h_cnt 10-11 (outputs one cycle later). vsync high for line 5. vid_sof only with pixel 0. 32 pixels consumed per frame.
3. Underflow: drop tvalid for 3 cycles mid-line 1 -> those 3 pixels = 24'hFF00FF, underflow=1, underflow_count=3. Raster timing unchanged. Subsequent data resumes in order.
4. Clear collision: clear_status asserted in the same cycle as an underflow -> underflow=0, count=0 next cycle.
5. Enable drop: enable=0 at line 2 -> frame completes (lines 2-3 still consumed). Then IDLE; de=0, syncs inactive, tready=0.
6. Async reset mid-line: aresetn low between clock edges -> all outputs take reset values immediately, without a clock edge. After release: IDLE, re-gated by prefill.
